// File: rtl/adc_fft_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : adc_fft_framer
// Purpose  : Upstream feeder for a 256-point streaming FFT core. Buffers an
//            irregular stream of unsigned 8-bit ADC samples in an internal
//            FIFO and emits gap-free frames of fftpts_in samples on an
//            Avalon-ST source (valid/ready, sop/eop, 8-bit real, zero imag).
//            A frame only starts once it is fully buffered, so it never
//            starves mid-frame.
// Optional : ADC_FRAMER_DC_BLOCK_EN - inserts a first-order DC blocker
//            (one extra register of write latency) ahead of the FIFO.
// Ports    : clk, reset_n (sync, active low)
//            enable        - accept samples / allow new frames
//            adc_valid/adc_data - offset-binary sample strobe
//            fft_len       - requested frame length (8..256, power of two)
//            clr_ovf       - clears ovf_sticky
//            sink_*        - Avalon-ST source towards the FFT sink
//            fftpts_in     - frame length, constant over a frame
//            inverse       - constant 0 (forward FFT)
//            ovf_sticky    - a sample was dropped on a full FIFO
//            frame_cnt     - completed frames (wrapping)
//            fifo_level    - current FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module adc_fft_framer #(
    parameter int FIFO_AW     = 10,
    parameter int DEFAULT_PTS = 256
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               adc_valid,
    input  logic [7:0]         adc_data,
    input  logic [8:0]         fft_len,
    input  logic               clr_ovf,
    output logic               sink_valid,
    input  logic               sink_ready,
    output logic [1:0]         sink_error,
    output logic               sink_sop,
    output logic               sink_eop,
    output logic [7:0]         sink_real,
    output logic [7:0]         sink_imag,
    output logic [8:0]         fftpts_in,
    output logic               inverse,
    output logic               ovf_sticky,
    output logic [15:0]        frame_cnt,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] LVL_FULL = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW+1)'(1);
    localparam logic [8:0]       PTS_DEF  = 9'(DEFAULT_PTS);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   level_q, level_d;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic               sop_q, sop_d;
    logic               eop_q, eop_d;
    logic [7:0]         real_q, real_d;
    logic [1:0]         err_q, err_d;
    logic [8:0]         idx_q, idx_d;
    logic [8:0]         pts_q, pts_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               ovf_q, ovf_d;
    logic               errp_q, errp_d;

    logic               wr_en;
    logic [7:0]         wr_data;
    logic               ovf_evt;
    logic               rd_en;
    logic               errp_clr;
    logic               full;
    logic [7:0]         x_s;
    logic [8:0]         len_dec;

    assign full = (level_q == LVL_FULL);
    // Offset binary to two's complement is a flip of the MSB.
    assign x_s  = adc_data ^ 8'h80;

    // ------------------------------------------------------------------
    // Write front end
    // ------------------------------------------------------------------
`ifdef ADC_FRAMER_DC_BLOCK_EN
    logic signed [15:0] acc_q, acc_d;
    logic               stg_v_q;
    logic [7:0]         stg_q;
    logic signed [15:0] acc_sh;
    logic signed [15:0] x_ext;
    logic signed [15:0] dc_diff;
    logic [7:0]         dc_sat;
    logic [FIFO_AW+1:0] lvl_eff;
    logic               full_eff;
    logic               accept;

    // A sample sitting in the stage register already owns a FIFO slot.
    assign lvl_eff  = {1'b0, level_q} + {{(FIFO_AW+1){1'b0}}, stg_v_q};
    assign full_eff = (lvl_eff >= {1'b0, LVL_FULL});
    assign accept   = adc_valid & enable & ~full_eff;
    assign ovf_evt  = adc_valid & enable & full_eff;

    assign acc_sh  = acc_q >>> 6;
    assign x_ext   = {{8{x_s[7]}}, x_s};
    assign dc_diff = x_ext - acc_sh;

    always_comb begin
        dc_sat = dc_diff[7:0];
        if (dc_diff > 16'sd127) begin
            dc_sat = 8'h7F;
        end else if (dc_diff < -16'sd128) begin
            dc_sat = 8'h80;
        end
        acc_d = acc_q;
        if (accept) begin
            acc_d = acc_q + x_ext - acc_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q   <= '0;
            stg_v_q <= 1'b0;
            stg_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            stg_v_q <= accept;
            if (accept) begin
                stg_q <= dc_sat;
            end
        end
    end

    assign wr_en   = stg_v_q;
    assign wr_data = stg_q;
`else
    assign wr_en   = adc_valid & enable & ~full;
    assign wr_data = x_s;
    assign ovf_evt = adc_valid & enable & full;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Length decode: only 8..256 powers of two are honoured.
    // ------------------------------------------------------------------
    always_comb begin
        case (fft_len)
            9'd8, 9'd16, 9'd32, 9'd64, 9'd128, 9'd256: len_dec = fft_len;
            default:                                   len_dec = PTS_DEF;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame FSM and output register
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        sop_d       = sop_q;
        eop_d       = eop_q;
        real_d      = real_q;
        err_d       = err_q;
        idx_d       = idx_q;
        pts_d       = pts_q;
        frame_cnt_d = frame_cnt_q;
        rd_en       = 1'b0;
        errp_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable && (level_q >= (FIFO_AW+1)'(len_dec))) begin
                    state_d  = S_STREAM;
                    pts_d    = len_dec;
                    rd_en    = 1'b1;
                    real_d   = mem_q[rd_ptr_q];
                    valid_d  = 1'b1;
                    sop_d    = 1'b1;
                    eop_d    = 1'b0;
                    idx_d    = 9'd0;
                    err_d    = {1'b0, errp_q};
                    errp_clr = 1'b1;
                end
            end
            S_STREAM: begin
                if (valid_q && sink_ready) begin
                    if (idx_q == (pts_q - 9'd1)) begin
                        valid_d     = 1'b0;
                        sop_d       = 1'b0;
                        eop_d       = 1'b0;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        // Whole frame was buffered at start, so the FIFO
                        // cannot be empty here.
                        rd_en  = 1'b1;
                        real_d = mem_q[rd_ptr_q];
                        idx_d  = idx_q + 9'd1;
                        sop_d  = 1'b0;
                        eop_d  = ((idx_q + 9'd1) == (pts_q - 9'd1));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO bookkeeping and sticky flags
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Overflow outranks a clear so a fresh drop is never lost.
        ovf_d = ovf_q;
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        // A drop in the same cycle a frame starts belongs to the next frame.
        errp_d = errp_q;
        if (ovf_evt) begin
            errp_d = 1'b1;
        end else if (errp_clr) begin
            errp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            valid_q     <= 1'b0;
            sop_q       <= 1'b0;
            eop_q       <= 1'b0;
            real_q      <= '0;
            err_q       <= '0;
            idx_q       <= '0;
            pts_q       <= PTS_DEF;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            errp_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            valid_q     <= valid_d;
            sop_q       <= sop_d;
            eop_q       <= eop_d;
            real_q      <= real_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            pts_q       <= pts_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            errp_q      <= errp_d;
        end
    end

    assign sink_valid = valid_q;
    assign sink_sop   = sop_q;
    assign sink_eop   = eop_q;
    assign sink_real  = real_q;
    assign sink_error = err_q;
    assign sink_imag  = 8'h00;
    assign inverse    = 1'b0;
    assign fftpts_in  = pts_q;
    assign ovf_sticky = ovf_q;
    assign frame_cnt  = frame_cnt_q;
    assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_fft_framer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_adc_fft_framer
// Purpose  : Self-checking bench for adc_fft_framer. A table of frame
//            records (requested length, expected fftpts, ready pattern,
//            data base) is applied in a loop; overflow, mid-frame reset and
//            the DC blocker (ADC_FRAMER_DC_BLOCK_EN) use hand-written
//            sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_fft_framer;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        adc_valid;
    logic [7:0]  adc_data;
    logic [8:0]  fft_len;
    logic        clr_ovf;
    logic        sink_valid;
    logic        sink_ready;
    logic [1:0]  sink_error;
    logic        sink_sop;
    logic        sink_eop;
    logic [7:0]  sink_real;
    logic [7:0]  sink_imag;
    logic [8:0]  fftpts_in;
    logic        inverse;
    logic        ovf_sticky;
    logic [15:0] frame_cnt;
    logic [AW:0] fifo_level;

    int n_cmp      = 0;
    int n_bad      = 0;
    int exp_frames = 0;

    typedef struct {
        logic [8:0] len;
        int         pts;
        bit         tog;
        int         base;
    } vec_t;

    vec_t tbl [9];

    adc_fft_framer #(.FIFO_AW(AW), .DEFAULT_PTS(256)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .fft_len    (fft_len),
        .clr_ovf    (clr_ovf),
        .sink_valid (sink_valid),
        .sink_ready (sink_ready),
        .sink_error (sink_error),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_real  (sink_real),
        .sink_imag  (sink_imag),
        .fftpts_in  (fftpts_in),
        .inverse    (inverse),
        .ovf_sticky (ovf_sticky),
        .frame_cnt  (frame_cnt),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},  32'(sink_valid), 0);
        chk({tag, "_sop"},    32'(sink_sop), 0);
        chk({tag, "_eop"},    32'(sink_eop), 0);
        chk({tag, "_real"},   32'(sink_real), 0);
        chk({tag, "_imag"},   32'(sink_imag), 0);
        chk({tag, "_error"},  32'(sink_error), 0);
        chk({tag, "_inv"},    32'(inverse), 0);
        chk({tag, "_ovf"},    32'(ovf_sticky), 0);
        chk({tag, "_fcnt"},   32'(frame_cnt), 0);
        chk({tag, "_pts"},    32'(fftpts_in), 256);
        chk({tag, "_level"},  32'(fifo_level), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        adc_valid  = 1'b0;
        clr_ovf    = 1'b0;
        sink_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        reset_n    = 1'b1;
        exp_frames = 0;
    endtask

    // One sample per cycle; returns at the negedge where level reflects all.
    task automatic feed(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            adc_valid = 1'b1;
            adc_data  = 8'(base + i);
        end
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    // Collect one frame; data model is (base+i) with the MSB flipped.
    task automatic collect(input int pts, input bit tog, input int base,
                           input logic [1:0] exp_err, input bit expect_empty);
        int         beats = 0;
        int         sops  = 0;
        int         eops  = 0;
        int         cyc   = 0;
        bit         hold  = 1'b0;
        bit         r;
        logic [7:0] h_real;
        logic       h_sop, h_eop;
        logic [1:0] h_err;
        while (beats < pts && cyc < 4 * pts + 50) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk("hold_real",  32'(sink_real), 32'(h_real));
                chk("hold_sop",   32'(sink_sop),  32'(h_sop));
                chk("hold_eop",   32'(sink_eop),  32'(h_eop));
                chk("hold_err",   32'(sink_error), 32'(h_err));
                chk("hold_valid", 32'(sink_valid), 1);
            end
            r = tog ? cyc[0] : 1'b1;
            sink_ready = r;
            hold = 1'b0;
            if (sink_valid) begin
                if (r) begin
                    chk("beat_real", 32'(sink_real), 32'(8'(base + beats) ^ 8'h80));
                    chk("beat_sop",  32'(sink_sop),  32'(beats == 0));
                    chk("beat_eop",  32'(sink_eop),  32'(beats == pts - 1));
                    chk("beat_pts",  32'(fftpts_in), 32'(pts));
                    chk("beat_err",  32'(sink_error), 32'(exp_err));
                    chk("beat_imag", 32'(sink_imag), 0);
                    chk("beat_inv",  32'(inverse), 0);
                    sops += int'(sink_sop);
                    eops += int'(sink_eop);
                    beats++;
                    // Length change mid-frame must not disturb this frame.
                    if (beats == 1) fft_len = 9'd8;
                end else begin
                    hold   = 1'b1;
                    h_real = sink_real;
                    h_sop  = sink_sop;
                    h_eop  = sink_eop;
                    h_err  = sink_error;
                end
            end
        end
        chk("frame_beats", 32'(beats), 32'(pts));
        chk("frame_sops",  32'(sops), 1);
        chk("frame_eops",  32'(eops), 1);
        exp_frames++;
        @(negedge clk);
        chk("post_valid", 32'(sink_valid), 0);
        chk("post_fcnt",  32'(frame_cnt), 32'(exp_frames));
        if (expect_empty) chk("post_level", 32'(fifo_level), 0);
    endtask

    task automatic run_vec(input vec_t v);
        sink_ready = 1'b1;
        enable     = 1'b1;
        fft_len    = v.len;
        feed(v.pts - 1, v.base);
        repeat (3) @(negedge clk);
        chk("short_no_valid", 32'(sink_valid), 0);
        chk("short_level",    32'(fifo_level), 32'(v.pts - 1));
        fft_len = v.len;
        feed(1, v.base + v.pts - 1);
        collect(v.pts, v.tog, v.base, 2'b00, 1'b1);
    endtask

    task automatic ovf_test();
        sink_ready = 1'b0;
        enable     = 1'b1;
        fft_len    = 9'd8;
        feed(DEPTH + 12, 8'h10);
        chk("ovf_set",    32'(ovf_sticky), 1);
        chk("ovf_level",  32'(fifo_level), 32'(DEPTH));
        chk("ovf_f1_err", 32'(sink_error), 0);
        chk("ovf_f1_sop", 32'(sink_sop), 1);
        // Clear and a new drop in the same cycle: the drop wins.
        clr_ovf   = 1'b1;
        adc_valid = 1'b1;
        @(negedge clk);
        chk("ovf_prio", 32'(ovf_sticky), 1);
        adc_valid = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(ovf_sticky), 0);
        collect(8, 1'b0, 8'h10,      2'b00, 1'b0);
        collect(8, 1'b0, 8'h10 + 8,  2'b01, 1'b0);
        collect(8, 1'b0, 8'h10 + 16, 2'b00, 1'b0);
    endtask

    task automatic midreset_test();
        bit found = 1'b0;
        do_reset();
        enable     = 1'b1;
        sink_ready = 1'b1;
        fft_len    = 9'd8;
        feed(8, 8'h80);
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (sink_valid && sink_real == 8'h03) found = 1'b1;
        end
        chk("mr_beat3_seen", 32'(found), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mr");
        reset_n    = 1'b1;
        exp_frames = 0;
        fft_len    = 9'd8;
        feed(8, 8'h20);
        collect(8, 1'b0, 8'h20, 2'b00, 1'b1);
    endtask

`ifdef ADC_FRAMER_DC_BLOCK_EN
    task automatic dc_test();
        do_reset();
        enable     = 1'b1;
        sink_ready = 1'b1;
        fft_len    = 9'd256;
        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    @(negedge clk);
                    adc_valid = 1'b1;
                    adc_data  = 8'hC0;
                end
                @(negedge clk);
                adc_valid = 1'b0;
            end
            begin
                int               beats = 0;
                int               cyc   = 0;
                logic signed [7:0] s;
                while (beats < 1792 && cyc < 8000) begin
                    @(negedge clk);
                    cyc++;
                    if (sink_valid) begin
                        if (beats >= 1536) begin
                            s = sink_real;
                            n_cmp++;
                            if (s > 8'sd1 || s < -8'sd1) begin
                                n_bad++;
                                $display("FAIL dc_conv beat %0d: got %0d required -1..1", beats, s);
                            end
                        end
                        beats++;
                    end
                end
                chk("dc_beats", 32'(beats), 1792);
            end
        join
    endtask
`endif

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        adc_valid  = 1'b0;
        adc_data   = 8'h00;
        fft_len    = 9'd8;
        clr_ovf    = 1'b0;
        sink_ready = 1'b0;

        tbl[0] = '{len: 9'd8,   pts: 8,   tog: 1'b0, base: 8'h80};
        tbl[1] = '{len: 9'd256, pts: 256, tog: 1'b1, base: 8'h00};
        tbl[2] = '{len: 9'd100, pts: 256, tog: 1'b0, base: 8'h40};
        tbl[3] = '{len: 9'd16,  pts: 16,  tog: 1'b1, base: 8'h11};
        tbl[4] = '{len: 9'd32,  pts: 32,  tog: 1'b0, base: 8'h22};
        tbl[5] = '{len: 9'd64,  pts: 64,  tog: 1'b1, base: 8'hF0};
        tbl[6] = '{len: 9'd128, pts: 128, tog: 1'b1, base: 8'h05};
        tbl[7] = '{len: 9'd0,   pts: 256, tog: 1'b0, base: 8'h99};
        tbl[8] = '{len: 9'd384, pts: 256, tog: 1'b1, base: 8'h7F};

        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        reset_n = 1'b1;

`ifdef ADC_FRAMER_DC_BLOCK_EN
        dc_test();
`else
        for (int i = 0; i < 9; i++) begin
            run_vec(tbl[i]);
        end
        ovf_test();
        midreset_test();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_fft_framer.md
Name: adc_fft_framer

Overview:
- Upstream feeder for the 256-point streaming FFT core.
- Accepts an irregular stream of unsigned 8-bit ADC samples and buffers them in an internal FIFO.
- Emits gap-free frames of exactly fftpts samples on an Avalon-ST source: valid/ready handshake, sop/eop, 8-bit real, zero imag.
- Output port names and widths match the FFT sink side, so the two connect directly.

Parameters:
- FIFO_AW, 10, FIFO address width; depth = 2**FIFO_AW samples (must be ≥ 9 so depth ≥ 512).
- DEFAULT_PTS, 256, frame length used when fft_len is invalid.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- enable  in  1  1 = accept ADC samples and start frames.
- adc_valid  in  1  one-cycle strobe, adc_data is valid.
- adc_data  in  8  unsigned offset-binary ADC sample.
- fft_len  in  9  requested frame length; legal values 8, 16, 32, 64, 128, 256.
- clr_ovf  in  1  clears ovf_sticky.
- sink_valid  out  1  output beat valid.
- sink_ready  in  1  FFT ready; readyLatency 0.
- sink_error  out  2  frame error flags.
- sink_sop  out  1  first beat of frame.
- sink_eop  out  1  last beat of frame.
- sink_real  out  8  two's-complement sample.
- sink_imag  out  8  constant 0.
- fftpts_in  out  9  frame length, latched for the whole frame.
- inverse  out  1  constant 0 (forward FFT).
- ovf_sticky  out  1  a sample was dropped because the FIFO was full.
- frame_cnt  out  16  frames completed (wraps).
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (reset_n = 0 at a clk edge):
  - FIFO pointers and level cleared.
  - State = IDLE.
  - sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error, inverse, ovf_sticky = 0.
  - frame_cnt = 0; fftpts_in = DEFAULT_PTS.
  - Reset mid-frame discards the frame; no eop is issued.
- Write path:
  - Write when adc_valid & enable & !full.
  - Stored value = adc_data ^ 8'h80 (offset binary to two's complement).
  - adc_valid while full: sample dropped, ovf_sticky <= 1, and error_pending <= 1.
  - clr_ovf clears ovf_sticky; a simultaneous overflow has priority and leaves ovf_sticky = 1.
  - enable = 0 blocks writes immediately.
- fifo_level:
  - Updates the cycle after a write or read; simultaneous write and read leave it unchanged.
  - Full when level = 2**FIFO_AW; empty when level = 0.
- Length decode: fft_len is legal only if it is a power of two in 8..256; any other value becomes DEFAULT_PTS. Decode is sampled only at the IDLE -> STREAM transition.
- State IDLE:
  - Go to STREAM when enable = 1 and fifo_level ≥ decoded length.
  - On that edge latch fftpts_in, and load the first beat into the output register from the FIFO head: sink_valid = 1, sink_sop = 1. The first beat therefore appears on the cycle after the level condition is seen.
  - sink_error = {1'b0, error_pending}; error_pending is cleared.
  - Because the whole frame is already buffered at start, the frame is never starved.
- State STREAM:
  - A beat transfers when sink_valid & sink_ready. Until it transfers, the output register holds all outputs stable.
  - After a transfer, the next FIFO word loads in the same cycle, so back-to-back beats run at 1/cycle.
  - beat_idx counts 0..len-1; sop = (idx == 0), eop = (idx == len-1).
  - On the eop transfer: sink_valid drops to 0, frame_cnt += 1, state -> IDLE.
  - Minimum gap between frames: one idle cycle.
  - enable = 0 mid-frame: the current frame completes normally and no new frame starts.
  - A change to fft_len mid-frame has no effect until the next frame.
- sink_imag = 0 and inverse = 0 always.
- sink_error stays constant for all beats of a frame.

Optional Feature:
- Macro: ADC_FRAMER_DC_BLOCK_EN.
- Defined:
  - Signed write-path samples pass through a DC blocker before the FIFO.
  - Accumulator acc (16-bit signed, reset 0) updates per written sample: acc <= acc + x - (acc >>> 6).
  - Stored value = sat8(x - (acc >>> 6)), saturating to -128..127.
  - Adds one register of write latency; fifo_level reflects the sample 2 cycles after adc_valid.
  - acc is cleared by reset only.
- Undefined: stored value = adc_data ^ 8'h80, with 1-cycle write latency.

Test Plan:
- fft_len = 8, sink_ready = 1, feed adc_data 0x80..0x87 on consecutive cycles -> one frame with sink_real 0x00..0x07, sop on beat 0, eop on beat 7, fftpts_in = 8, frame_cnt = 1.
- fft_len = 256, sink_ready toggling 1/0 every cycle, 256 samples -> all 256 beats delivered in order; outputs stable while ready = 0; exactly one sop and one eop.
- fft_len = 100 (illegal) -> fftpts_in = 256; no frame until 256 samples are buffered.
- sink_ready = 0 with continuous adc_valid beyond 2**FIFO_AW samples -> ovf_sticky = 1; the next frame has sink_error = 2'b01; clr_ovf pulse -> ovf_sticky = 0.
- Assert reset_n = 0 at beat 3 of an 8-point frame -> next cycle all outputs at reset values and fifo_level = 0; the next frame begins with sop.
- Build with ADC_FRAMER_DC_BLOCK_EN, constant adc_data = 0xC0 for 2000 samples -> sink_real converges to within ±1 of 0.
